// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types and sensor codes for the parking lane controller
package parking_pkg;

  // Lane arbitration / grant states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT_IN  = 2'd1,
    ST_GRANT_OUT = 2'd2
  } lane_state_e;

  // Side that most recently won arbitration; drives round-robin on a tie
  typedef enum logic {
    LG_IN  = 1'b0,
    LG_OUT = 1'b1
  } last_grant_e;

  // Passage decoder states; comment gives the sensor code {a,b} held in that state
  typedef enum logic [2:0] {
    P_IDLE = 3'd0,  // 00
    P_IN1  = 3'd1,  // 10
    P_IN2  = 3'd2,  // 11
    P_IN3  = 3'd3,  // 01
    P_OUT1 = 3'd4,  // 01
    P_OUT2 = 3'd5,  // 11
    P_OUT3 = 3'd6   // 10
  } passage_state_e;

  // Sensor pair codes {a, b}
  localparam logic [1:0] AB_NONE = 2'b00;
  localparam logic [1:0] AB_A    = 2'b10;
  localparam logic [1:0] AB_BOTH = 2'b11;
  localparam logic [1:0] AB_B    = 2'b01;

endpackage

// File: rtl/car_passage_fsm.sv
// rtl/car_passage_fsm.sv - decodes the outer/inner beam sequence into enter/exit events
//   clk, reset      : clock, synchronous active-high reset
//   a, b            : outer / inner beam, 1 = blocked
//   enter_evt       : 1-cycle pulse on the final 00 of 00-10-11-01-00
//   exit_evt        : 1-cycle pulse on the final 00 of 00-01-11-10-00
module car_passage_fsm
  import parking_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic enter_evt,
  output logic exit_evt
);

  passage_state_e state_q, state_d;
  logic [1:0]     ab;

  assign ab = {a, b};

  // Events are Mealy outputs so the top FSM acts on the same edge the final 00 is seen.
  // A backward step retraces the sequence; any other jump abandons it silently.
  always_comb begin
    state_d   = state_q;
    enter_evt = 1'b0;
    exit_evt  = 1'b0;
    case (state_q)
      P_IDLE: begin
        if (ab == AB_A)      state_d = P_IN1;
        else if (ab == AB_B) state_d = P_OUT1;
        else                 state_d = P_IDLE;
      end
      P_IN1: begin
        case (ab)
          AB_A:    state_d = P_IN1;
          AB_BOTH: state_d = P_IN2;
          default: state_d = P_IDLE;
        endcase
      end
      P_IN2: begin
        case (ab)
          AB_BOTH: state_d = P_IN2;
          AB_B:    state_d = P_IN3;
          AB_A:    state_d = P_IN1;
          default: state_d = P_IDLE;
        endcase
      end
      P_IN3: begin
        case (ab)
          AB_B:    state_d = P_IN3;
          AB_BOTH: state_d = P_IN2;
          AB_NONE: begin
            state_d   = P_IDLE;
            enter_evt = 1'b1;
          end
          default: state_d = P_IDLE;
        endcase
      end
      P_OUT1: begin
        case (ab)
          AB_B:    state_d = P_OUT1;
          AB_BOTH: state_d = P_OUT2;
          default: state_d = P_IDLE;
        endcase
      end
      P_OUT2: begin
        case (ab)
          AB_BOTH: state_d = P_OUT2;
          AB_A:    state_d = P_OUT3;
          AB_B:    state_d = P_OUT1;
          default: state_d = P_IDLE;
        endcase
      end
      P_OUT3: begin
        case (ab)
          AB_A:    state_d = P_OUT3;
          AB_BOTH: state_d = P_OUT2;
          AB_NONE: begin
            state_d  = P_IDLE;
            exit_evt = 1'b1;
          end
          default: state_d = P_IDLE;
        endcase
      end
      default: state_d = P_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= P_IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: rtl/parking_lane_controller.sv
// rtl/parking_lane_controller.sv - shared-lane barrier arbiter with occupancy count
//   clk, reset            : clock, synchronous active-high reset
//   entry_req, exit_req   : level requests from the outside / inside posts
//   a, b                  : outer / inner beam sensors, 1 = blocked
//   gate_open             : barrier raised
//   grant_in, grant_out   : lane granted to an entering / exiting car
//   full                  : occupancy == CAPACITY
//   occupancy             : current car count
//   err                   : 1-cycle pulse on timeout, wrong-direction or unexpected passage
module parking_lane_controller
  import parking_pkg::*;
#(
  parameter int CAPACITY = 15,
  parameter int CNT_W    = 4,
  parameter int TIMEOUT  = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             a,
  input  logic             b,
  output logic             gate_open,
  output logic             grant_in,
  output logic             grant_out,
  output logic             full,
  output logic [CNT_W-1:0] occupancy,
  output logic             err
);

  localparam int               TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CAP_C    = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  lane_state_e      state_q, state_d;
  last_grant_e      last_q, last_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             gate_open_q, gate_open_d;
  logic             grant_in_q, grant_in_d;
  logic             grant_out_q, grant_out_d;
  logic             err_q, err_d;
  logic             enter_evt, exit_evt;
  logic             entry_elig, exit_elig;

  car_passage_fsm u_passage (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .enter_evt (enter_evt),
    .exit_evt  (exit_evt)
  );

  assign full       = (occ_q == CAP_C);
  assign entry_elig = entry_req & ~full;
  assign exit_elig  = exit_req & (occ_q != '0);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    occ_d   = occ_q;
    timer_d = timer_q;
    err_d   = 1'b0;
    case (state_q)
      ST_GRANT_IN: begin
        timer_d = timer_q + 1'b1;
        if (enter_evt) begin
          state_d = ST_IDLE;
          timer_d = '0;
          // Unreachable while entry is gated by full; kept so the count can never wrap
          if (occ_q == CAP_C) err_d = 1'b1;
          else                occ_d = occ_q + 1'b1;
        end else if (exit_evt || timer_q == TMR_LAST) begin
          state_d = ST_IDLE;
          timer_d = '0;
          err_d   = 1'b1;
        end
      end
      ST_GRANT_OUT: begin
        timer_d = timer_q + 1'b1;
        if (exit_evt) begin
          state_d = ST_IDLE;
          timer_d = '0;
          if (occ_q == '0) err_d = 1'b1;
          else             occ_d = occ_q - 1'b1;
        end else if (enter_evt || timer_q == TMR_LAST) begin
          state_d = ST_IDLE;
          timer_d = '0;
          err_d   = 1'b1;
        end
      end
      default: begin
        timer_d = '0;
        // A passage nobody was granted is flagged but never counted
        if (enter_evt || exit_evt) err_d = 1'b1;
        // Tie goes to the side that did not win last; full removes entry from the tie
        if (entry_elig && (!exit_elig || last_q == LG_OUT)) begin
          state_d = ST_GRANT_IN;
          last_d  = LG_IN;
        end else if (exit_elig) begin
          state_d = ST_GRANT_OUT;
          last_d  = LG_OUT;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
    gate_open_d = (state_d != ST_IDLE);
    grant_in_d  = (state_d == ST_GRANT_IN);
    grant_out_d = (state_d == ST_GRANT_OUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_q      <= LG_OUT;
      occ_q       <= '0;
      timer_q     <= '0;
      gate_open_q <= 1'b0;
      grant_in_q  <= 1'b0;
      grant_out_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      occ_q       <= occ_d;
      timer_q     <= timer_d;
      gate_open_q <= gate_open_d;
      grant_in_q  <= grant_in_d;
      grant_out_q <= grant_out_d;
      err_q       <= err_d;
    end
  end

  assign gate_open = gate_open_q;
  assign grant_in  = grant_in_q;
  assign grant_out = grant_out_q;
  assign occupancy = occ_q;
  assign err       = err_q;

endmodule

// File: tb/tb_parking_lane_controller.sv
// tb/tb_parking_lane_controller.sv - self-checking bench for parking_lane_controller
module tb_parking_lane_controller;

  localparam int CAP = 2;
  localparam int TMO = 20;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          entry_req, exit_req, a, b;
  logic          gate_open, grant_in, grant_out, full, err;
  logic [CW-1:0] occupancy;

  int n_assert = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  parking_lane_controller #(.CAPACITY(CAP), .CNT_W(CW), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .entry_req (entry_req),
    .exit_req  (exit_req),
    .a         (a),
    .b         (b),
    .gate_open (gate_open),
    .grant_in  (grant_in),
    .grant_out (grant_out),
    .full      (full),
    .occupancy (occupancy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_grant: 0 none, 1 in, 2 out.  m_pos: +k = k steps into entry sequence, -k into exit.
  logic [1:0] in_seq  [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [1:0] out_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int m_grant = 0, m_last = 2, m_occ = 0, m_timer = 0, m_pos = 0;
  bit m_err = 1'b0;

  always @(posedge clk) begin
    logic [1:0] ab;
    logic [1:0] cur, nxt, prv;
    int  k, np, win;
    bit  ev_in, ev_out, ein, eout;
    ab = {a, b};
    ev_in = 1'b0;
    ev_out = 1'b0;
    if (m_pos == 0) begin
      if (ab == in_seq[1])       np = 1;
      else if (ab == out_seq[1]) np = -1;
      else                       np = 0;
    end else begin
      k = (m_pos > 0) ? m_pos : -m_pos;
      cur = (m_pos > 0) ? in_seq[k] : out_seq[k];
      nxt = (m_pos > 0) ? in_seq[(k + 1) % 4] : out_seq[(k + 1) % 4];
      prv = (m_pos > 0) ? in_seq[k - 1] : out_seq[k - 1];
      if (ab == cur) np = k;
      else if (ab == nxt) begin
        np = (k == 3) ? 0 : k + 1;
        if (k == 3) begin
          if (m_pos > 0) ev_in = 1'b1;
          else           ev_out = 1'b1;
        end
      end else if (ab == prv) np = k - 1;
      else np = 0;
      if (m_pos < 0) np = -np;
    end

    if (reset) begin
      m_grant = 0; m_last = 2; m_occ = 0; m_timer = 0; m_pos = 0; m_err = 1'b0;
    end else begin
      m_pos = np;
      m_err = 1'b0;
      if (m_grant == 0) begin
        if (ev_in || ev_out) m_err = 1'b1;
        ein  = entry_req && (m_occ != CAP);
        eout = exit_req && (m_occ != 0);
        if (ein && eout) win = (m_last == 2) ? 1 : 2;
        else if (ein)    win = 1;
        else if (eout)   win = 2;
        else             win = 0;
        if (win != 0) begin
          m_grant = win; m_last = win; m_timer = 0;
        end
      end else begin
        if ((m_grant == 1 && ev_in) || (m_grant == 2 && ev_out)) begin
          if (m_grant == 1) begin
            if (m_occ == CAP) m_err = 1'b1; else m_occ = m_occ + 1;
          end else begin
            if (m_occ == 0) m_err = 1'b1; else m_occ = m_occ - 1;
          end
          m_grant = 0;
        end else if (ev_in || ev_out || m_timer == TMO - 1) begin
          m_err = 1'b1;
          m_grant = 0;
        end else begin
          m_timer = m_timer + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc gate_open", 32'(gate_open), 32'(m_grant != 0));
      chk("cyc grant_in", 32'(grant_in), 32'(m_grant == 1));
      chk("cyc grant_out", 32'(grant_out), 32'(m_grant == 2));
      chk("cyc full", 32'(full), 32'(m_occ == CAP));
      chk("cyc occupancy", 32'(occupancy), 32'(m_occ));
      chk("cyc err", 32'(err), 32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic step(input logic [1:0] ab, input int n);
    {a, b} = ab;
    cyc(n);
  endtask

  task automatic seq_in();
    step(2'b10, 5); step(2'b11, 5); step(2'b01, 5); step(2'b00, 1);
  endtask

  task automatic seq_out();
    step(2'b01, 5); step(2'b11, 5); step(2'b10, 5); step(2'b00, 1);
  endtask

  task automatic do_entry();
    entry_req = 1'b1; cyc(1); entry_req = 1'b0;
    seq_in();
  endtask

  task automatic do_exit();
    exit_req = 1'b1; cyc(1); exit_req = 1'b0;
    seq_out();
  endtask

  initial begin
    int first_err, n_err;
    reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0; a = 1'b0; b = 1'b0;
    cyc(2);
    check_en = 1'b1;
    chk("reset gate_open", 32'(gate_open), 0);
    chk("reset occupancy", 32'(occupancy), 0);
    chk("reset err", 32'(err), 0);
    reset = 1'b0;
    cyc(2);

    // 1. entry
    entry_req = 1'b1; cyc(1);
    chk("t1 grant_in", 32'(grant_in), 1);
    chk("t1 gate_open", 32'(gate_open), 1);
    entry_req = 1'b0;
    seq_in();
    chk("t1 occupancy", 32'(occupancy), 1);
    chk("t1 gate closed", 32'(gate_open), 0);
    cyc(3);

    // 2. exit, then exit with empty lot
    exit_req = 1'b1; cyc(1);
    chk("t2 grant_out", 32'(grant_out), 1);
    exit_req = 1'b0;
    seq_out();
    chk("t2 occupancy", 32'(occupancy), 0);
    exit_req = 1'b1; cyc(3);
    chk("t2 empty no grant", 32'(grant_out), 0);
    exit_req = 1'b0; cyc(2);

    // 3. full
    do_entry(); cyc(1);
    do_entry(); cyc(1);
    chk("t3 full", 32'(full), 1);
    chk("t3 occupancy", 32'(occupancy), 2);
    entry_req = 1'b1; cyc(5);
    chk("t3 full no grant_in", 32'(grant_in), 0);
    exit_req = 1'b1; cyc(1);
    chk("t3 exit wins", 32'(grant_out), 1);
    entry_req = 1'b0; exit_req = 1'b0;
    seq_out();
    chk("t3 occupancy after exit", 32'(occupancy), 1);
    cyc(2);

    // 4. round-robin with both requests held
    entry_req = 1'b1; exit_req = 1'b1; cyc(1);
    chk("t4 rr first in", 32'(grant_in), 1);
    seq_in(); cyc(1);
    chk("t4 rr then out", 32'(grant_out), 1);
    seq_out(); cyc(1);
    chk("t4 rr then in", 32'(grant_in), 1);
    entry_req = 1'b0; exit_req = 1'b0;
    seq_in();
    chk("t4 occupancy", 32'(occupancy), 2);
    cyc(1);
    do_exit(); cyc(2);
    chk("t4 occupancy after exit", 32'(occupancy), 1);

    // 5. backout then timeout
    entry_req = 1'b1; cyc(1); entry_req = 1'b0;
    chk("t5 grant_in", 32'(grant_in), 1);
    {a, b} = 2'b10;
    first_err = -1; n_err = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (i == 5) {a, b} = 2'b00;
      if (err === 1'b1) begin
        n_err++;
        if (first_err < 0) first_err = i;
      end
    end
    chk("t5 err cycle", 32'(first_err), 20);
    chk("t5 err pulses", 32'(n_err), 1);
    chk("t5 occupancy", 32'(occupancy), 1);
    chk("t5 gate closed", 32'(gate_open), 0);

    // 6. reset mid-passage
    entry_req = 1'b1; cyc(1); entry_req = 1'b0;
    step(2'b10, 5); step(2'b11, 2);
    reset = 1'b1; cyc(1);
    chk("t6 occupancy", 32'(occupancy), 0);
    chk("t6 gate_open", 32'(gate_open), 0);
    chk("t6 grant_in", 32'(grant_in), 0);
    reset = 1'b0;
    step(2'b11, 3); step(2'b01, 5); step(2'b00, 5);
    chk("t6 occupancy after", 32'(occupancy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
